// File: rtl/text_entry_buffer.sv
// text_entry_buffer
// Builds one line of text from characters given one at a time. The line is
// left-justified, and every empty slot holds PAD_CHAR. The line feeds the
// LCD/VGA text path.
// A character is taken on each rising edge of `next`. Backspace removes the
// last character. ENTER completes a non-empty line. `clear` empties the line.
//
// Ports
//   Clk        in   system clock
//   Reset      in   asynchronous, active-high reset
//   data_in    in   character code, sampled when an edge of `next` is accepted
//   next       in   strobe; only its rising edge is used
//   clear      in   synchronous clear back to an empty ENTRY line
//   textOut    out  line buffer; char i at [(MAX_CHARS-i)*CHAR_W-1 -: CHAR_W]
//   count      out  number of valid characters
//   done       out  high while the line is complete (DONE)
//   full       out  count == MAX_CHARS
//   overflow   out  one-cycle pulse when a printable character is rejected
//   state_o    out  current FSM state (0 = ENTRY, 1 = DONE), for debug
//
// Handshake: no valid/ready handshake. A character is offered by raising
// `next`. It is consumed on the first clock edge that sees `next` high after
// `next` was seen low. The result is visible one cycle later.
module text_entry_buffer #(
  parameter int                CHAR_W     = 8,
  parameter int                MAX_CHARS  = 32,
  parameter int                CNT_W      = 6,
  parameter logic [CHAR_W-1:0] PAD_CHAR   = CHAR_W'(8'h20),
  parameter logic [CHAR_W-1:0] ENTER_CODE = CHAR_W'(8'h0D),
  parameter logic [CHAR_W-1:0] BS_CODE    = CHAR_W'(8'h08)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [CHAR_W-1:0]           data_in,
  input  logic                        next,
  input  logic                        clear,
  output logic [MAX_CHARS*CHAR_W-1:0] textOut,
  output logic [CNT_W-1:0]            count,
  output logic                        done,
  output logic                        full,
  output logic                        overflow,
  output logic                        state_o
);

  typedef enum logic {ST_ENTRY = 1'b0, ST_DONE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CHARS);

  state_t            state_q, state_d;
  logic [CHAR_W-1:0] text_q [MAX_CHARS];
  logic [CHAR_W-1:0] text_d [MAX_CHARS];
  logic [CNT_W-1:0]  count_q, count_d, count_m1;
  logic              ovf_q, ovf_d;
  logic              next_dly_q;
  logic              armed_q;
  logic              accept;
  logic [31:0]       code;
  logic              is_print, is_bs, is_enter;

  // armed_q stays low after reset until `next` has been seen low. Because of
  // this, a `next` that is held high through reset release is not taken as
  // an edge.
  assign accept   = next & ~next_dly_q & armed_q;

  // Zero-extend the code so that the printable range 0x20..0x7E also works
  // for narrow (7-bit) characters.
  assign code     = 32'(data_in);
  assign is_print = (code >= 32'h20) && (code <= 32'h7E);
  assign is_bs    = ~is_print && (data_in == BS_CODE);
  assign is_enter = ~is_print && ~is_bs && (data_in == ENTER_CODE);
  assign count_m1 = count_q - CNT_W'(1);

  // FSM: state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= ST_ENTRY;
    else       state_q <= state_d;
  end

  // FSM: next state. An empty line cannot complete.
  always_comb begin
    state_d = state_q;
    if (clear)
      state_d = ST_ENTRY;
    else if (state_q == ST_ENTRY && accept && is_enter && count_q != '0)
      state_d = ST_DONE;
  end

  // FSM: outputs
  always_comb begin
    done    = (state_q == ST_DONE);
    state_o = state_q;
  end

  // Line datapath. clear takes priority over an accepted character.
  always_comb begin
    text_d  = text_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    if (clear) begin
      for (int i = 0; i < MAX_CHARS; i++) text_d[i] = PAD_CHAR;
      count_d = '0;
    end else if (state_q == ST_ENTRY && accept) begin
      if (is_print) begin
        if (count_q < MAX_CNT) begin
          for (int i = 0; i < MAX_CHARS; i++)
            if (CNT_W'(i) == count_q) text_d[i] = data_in;
          count_d = count_q + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (is_bs && count_q != '0) begin
        for (int i = 0; i < MAX_CHARS; i++)
          if (CNT_W'(i) == count_m1) text_d[i] = PAD_CHAR;
        count_d = count_m1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MAX_CHARS; i++) text_q[i] <= PAD_CHAR;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      next_dly_q <= 1'b0;
      armed_q    <= 1'b0;
    end else begin
      text_q     <= text_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      next_dly_q <= next;
      armed_q    <= armed_q | ~next;
    end
  end

  always_comb begin
    textOut = '0;
    for (int i = 0; i < MAX_CHARS; i++)
      textOut[(MAX_CHARS-i)*CHAR_W-1 -: CHAR_W] = text_q[i];
  end

  assign count    = count_q;
  assign full     = (count_q == MAX_CNT);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_text_entry_buffer.sv
module tb_text_entry_buffer;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  // ---------------- main DUT (defaults) ----------------
  logic [7:0]   data_in = '0;
  logic         next = 1'b0;
  logic         clear = 1'b0;
  logic [255:0] textOut;
  logic [5:0]   count;
  logic         done, full, overflow, state_o;

  text_entry_buffer u_dut (
    .Clk(Clk), .Reset(Reset), .data_in(data_in), .next(next), .clear(clear),
    .textOut(textOut), .count(count), .done(done), .full(full),
    .overflow(overflow), .state_o(state_o)
  );

  // ---------------- narrow DUT (16 chars x 7 bits) ----------------
  logic [6:0]   data16 = '0;
  logic         next16 = 1'b0;
  logic         clear16 = 1'b0;
  logic [111:0] text16;
  logic [4:0]   count16;
  logic         done16, full16, ovf16, state16;

  text_entry_buffer #(.CHAR_W(7), .MAX_CHARS(16), .CNT_W(5)) u_dut16 (
    .Clk(Clk), .Reset(Reset), .data_in(data16), .next(next16), .clear(clear16),
    .textOut(text16), .count(count16), .done(done16), .full(full16),
    .overflow(ovf16), .state_o(state16)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The line is a queue of characters. Reset treats `next` as already high,
  // so only a low-to-high change seen after reset counts as a press.
  logic [7:0] m_line[$];
  bit m_done, m_ovf, m_prev;

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_line.delete(); m_done = 0; m_ovf = 0; m_prev = 1;
    end else begin
      m_ovf = 0;
      if (clear) begin
        m_line.delete(); m_done = 0;
      end else if (next && !m_prev && !m_done) begin
        if (data_in >= 8'h20 && data_in <= 8'h7E) begin
          if (m_line.size() < 32) m_line.push_back(data_in);
          else m_ovf = 1;
        end else if (data_in == 8'h08) begin
          if (m_line.size() > 0) void'(m_line.pop_back());
        end else if (data_in == 8'h0D) begin
          if (m_line.size() > 0) m_done = 1;
        end
      end
      m_prev = next;
    end
  end

  function automatic logic [255:0] model_text();
    logic [255:0] v;
    v = '0;
    for (int i = 0; i < 32; i++)
      v[(32-i)*8-1 -: 8] = (i < m_line.size()) ? m_line[i] : 8'h20;
    return v;
  endfunction

  // Scoreboard: compare the DUT with the model on every falling edge
  always @(negedge Clk) begin
    if (!Reset) begin
      check("text",     textOut,         model_text());
      check("count",    256'(count),     256'(m_line.size()));
      check("done",     256'(done),      256'(m_done));
      check("full",     256'(full),      256'(m_line.size() == 32));
      check("overflow", 256'(overflow),  256'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge Clk); #1;
  endtask

  task automatic press(input logic [7:0] c);
    data_in = c; next = 1'b1; step();
    next = 1'b0; step();
  endtask

  task automatic do_clear();
    clear = 1'b1; step();
    clear = 1'b0; step();
  endtask

  task automatic press16(input logic [6:0] c);
    data16 = c; next16 = 1'b1; step();
    next16 = 1'b0; step();
  endtask

  localparam logic [255:0] ALL_PAD = {32{8'h20}};

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    check("rst_text", textOut, ALL_PAD);
    check("rst_count", 256'(count), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_ovf", 256'(overflow), 256'(0));
    check("rst_full", 256'(full), 256'(0));
    Reset = 1'b0; step();

    // "Hi"
    press(8'h48); press(8'h69);
    check("hi_top", 256'(textOut[255:240]), 256'(16'h4869));
    check("hi_rest", 256'(textOut[239:0]), 256'({30{8'h20}}));
    check("hi_count", 256'(count), 256'(2));
    check("hi_done", 256'(done), 256'(0));

    // Codes outside every class are ignored
    press(8'h01); press(8'h7F);
    check("ign_count", 256'(count), 256'(2));

    // next held high for 10 cycles gives one 'A'
    do_clear();
    data_in = 8'h41; next = 1'b1; repeat (10) step();
    next = 1'b0; step();
    check("hold_count", 256'(count), 256'(1));
    check("hold_s0", 256'(textOut[255:248]), 256'(8'h41));
    check("hold_s1", 256'(textOut[247:240]), 256'(8'h20));

    // Fill with 32 'x', then 'y' overflows
    do_clear();
    for (int i = 0; i < 32; i++) press(8'h78);
    check("fill_full", 256'(full), 256'(1));
    check("fill_count", 256'(count), 256'(32));
    data_in = 8'h79; next = 1'b1; step();
    check("ovf_pulse", 256'(overflow), 256'(1));
    next = 1'b0; step();
    check("ovf_gone", 256'(overflow), 256'(0));
    check("ovf_last", 256'(textOut[7:0]), 256'(8'h78));
    // A full line can complete, and full stays high in DONE
    press(8'h0D);
    check("full_done", 256'(done), 256'(1));
    check("full_in_done", 256'(full), 256'(1));

    // Backspace
    do_clear();
    press(8'h08);
    check("bs0_count", 256'(count), 256'(0));
    press(8'h61); press(8'h62); press(8'h08);
    check("bs_count", 256'(count), 256'(1));
    check("bs_s1", 256'(textOut[247:240]), 256'(8'h20));
    check("bs_s0", 256'(textOut[255:248]), 256'(8'h61));

    // ENTER handling
    do_clear();
    press(8'h0D);
    check("ent_empty", 256'(done), 256'(0));
    press(8'h61); press(8'h0D);
    check("ent_done", 256'(done), 256'(1));
    check("ent_state", 256'(state_o), 256'(1));
    press(8'h7A);
    check("done_frozen", 256'(count), 256'(1));
    do_clear();
    check("clr_done", 256'(done), 256'(0));
    check("clr_count", 256'(count), 256'(0));
    check("clr_text", textOut, ALL_PAD);

    // Asynchronous reset at count=5, between clock edges
    for (int i = 0; i < 5; i++) press(8'h30 + 8'(i));
    check("pre_rst_count", 256'(count), 256'(5));
    #2 Reset = 1'b1;
    #1;
    check("arst_count", 256'(count), 256'(0));
    check("arst_text", textOut, ALL_PAD);
    step();
    Reset = 1'b0; step();

    // next held high through reset release: no accept
    data_in = 8'h42; next = 1'b1; step();
    Reset = 1'b1; step(); Reset = 1'b0;
    repeat (3) step();
    check("hold_rst_count", 256'(count), 256'(0));
    next = 1'b0; step();

    // clear together with an accepted 'q': clear wins
    press(8'h61);
    data_in = 8'h71; next = 1'b1; clear = 1'b1; step();
    next = 1'b0; clear = 1'b0; step();
    check("clrq_count", 256'(count), 256'(0));
    check("clrq_text", textOut, ALL_PAD);

    // Narrow instance: 16 chars of 7 bits
    for (int i = 0; i < 16; i++) press16(7'h61 + 7'(i));
    check("n16_count", 256'(count16), 256'(16));
    check("n16_full", 256'(full16), 256'(1));
    check("n16_first", 256'(text16[111:105]), 256'(7'h61));
    check("n16_last", 256'(text16[6:0]), 256'(7'h70));
    data16 = 7'h5A; next16 = 1'b1; step();
    check("n16_ovf", 256'(ovf16), 256'(1));
    next16 = 1'b0; step();
    check("n16_ovf_gone", 256'(ovf16), 256'(0));
    check("n16_last_kept", 256'(text16[6:0]), 256'(7'h70));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_entry_buffer.md
Name: text_entry_buffer

Overview:
- Parametrised successor to the fixed 8-bit, 32-character text accumulator.
- Collects characters presented on data_in, one per rising edge of next, into a left-justified, space-padded text line for the LCD/VGA text path.
- Adds backspace, enter-terminated completion, a clear input, a fill counter, and full/overflow status.

Parameters:
- CHAR_W, 8, bits per character; must be >= 7.
- MAX_CHARS, 32, line capacity in characters.
- CNT_W, 6, count width; must satisfy 2^CNT_W > MAX_CHARS.
- PAD_CHAR, 8'h20, fill code for empty positions.
- ENTER_CODE, 8'h0D, terminates entry.
- BS_CODE, 8'h08, backspace.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- data_in  in  CHAR_W  character code, sampled on an accepted next edge.
- next  in  1  strobe; level or pulse; only its rising edge is used.
- clear  in  1  synchronous: empty the buffer and return to ENTRY.
- textOut  out  MAX_CHARS*CHAR_W  line buffer. Char 0 is at [MAX_CHARS*CHAR_W-1 -: CHAR_W], char i is at [(MAX_CHARS-i)*CHAR_W-1 -: CHAR_W].
- count  out  CNT_W  number of valid characters.
- done  out  1  high while in DONE.
- full  out  1  count == MAX_CHARS.
- overflow  out  1  one-cycle pulse when a printable character is rejected.

Behaviour:
- Reset (async, any time including mid-entry):
  - state=ENTRY, every textOut slot=PAD_CHAR, count=0.
  - done=0, overflow=0, next_d=0.
- Edge detect:
  - next_d <= next every cycle, including during clear.
  - Accepted edge = next & ~next_d.
  - A held-high next yields exactly one accept.
  - next held high through reset release does not produce an accept.
- Latency: all outputs change on the clock edge that samples the accept; results are visible 1 cycle after the edge is presented.
- Code classes (data_in compared zero-extended):
  - printable = 0x20..0x7E
  - ENTER_CODE
  - BS_CODE
  - anything else = ignored, no state change.
- FSM states: ENTRY, DONE.
- ENTRY, accepted printable:
  - if count<MAX_CHARS: slot[count]<=data_in, count++.
  - else: buffer unchanged, overflow pulses high for 1 cycle.
- ENTRY, accepted BS_CODE:
  - if count>0: slot[count-1]<=PAD_CHAR, count--.
  - else: no-op.
- ENTRY, accepted ENTER_CODE:
  - if count>0: state<=DONE.
  - else: ignored, since an empty line cannot complete.
- DONE:
  - done=1; textOut and count frozen; all accepted edges ignored.
  - Leave DONE only via clear or Reset.
- clear=1 (either state): same register values as reset, applied synchronously.
- Simultaneous clear and accepted edge: clear wins and the character is discarded.
- full is combinational from count; it stays high in DONE when the line was completed full.
- Positions >= count always hold PAD_CHAR.

Test Plan:
- Reset, then accept edges with 'H'(0x48) and 'i'(0x69) -> textOut top bytes 0x48,0x69, remaining 30 slots 0x20, count=2, done=0.
- Hold next high for 10 cycles with data_in=0x41 -> exactly one 'A' stored, count=1.
- Enter 32 'x' (0x78), then one 'y' -> full=1, count=32, overflow high for exactly 1 cycle, last slot still 0x78.
- Backspace at count=0 -> no change. Then 'a','b', BS -> count=1, slot1=0x20.
- ENTER at count=0 -> done stays 0. 'a', ENTER -> done=1. A further 'z' edge is ignored. clear -> done=0, count=0, all slots 0x20.
- Assert Reset asynchronously between clock edges at count=5 -> outputs return to reset values immediately without a clock edge.
- Clear coincident with an accepted 'q' edge -> count=0, no 'q' stored.
- Regression at MAX_CHARS=16, CHAR_W=7, CNT_W=5: 16 chars fill, 17th sets overflow, textOut width is 112.
